// File: rtl/delay_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : delay_tap_scheduler
// Purpose  : Time-multiplexes NTAPS delay-line reflections through a single
//            RAM read port and a single gain multiplier. Each sample tick
//            starts one pass: every tap is read, scaled by its level and
//            summed. The saturated sum is presented on mix_o.
// Ports    : clk_i            - system clock
//            srst_i           - synchronous reset, active-high
//            sample_tick_i    - one-cycle pulse per audio sample, starts a pass
//            wr_addr_i        - current delay-line write pointer
//            tap_delay_i      - per-tap delay, tap k at [k*AWIDTH +: AWIDTH], 0 = off
//            tap_level_i      - per-tap gain, unsigned 8 bit, 255 ~ x1.0
//            rd_en_o/rd_addr_o- RAM read strobe and address
//            rd_data_i        - RAM data, valid RD_LATENCY cycles after rd_en_o
//            mix_o            - saturated mix, held between passes
//            mix_valid_o      - one-cycle pulse when mix_o updates
//            busy_o           - high while a pass is in progress
//            overrun_o        - sticky: tick arrived while busy
//            unmute_trigger_o - per-tap pulse when a tap delay changed
// Options  : DELAY_TAP_SCHEDULER_UNMUTE_EN - when defined, a tap whose delay
//            changed restarts from gain 0 and ramps up by 1 per pass
//            (effective gain = min(ramp, level)) to hide the delay jump.
// Revision : 1.0 - initial release
// ============================================================================
module delay_tap_scheduler #(
    parameter int DWIDTH     = 16,
    parameter int AWIDTH     = 15,
    parameter int NTAPS      = 4,
    parameter int RD_LATENCY = 2
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    sample_tick_i,
    input  logic [AWIDTH-1:0]       wr_addr_i,
    input  logic [NTAPS*AWIDTH-1:0] tap_delay_i,
    input  logic [NTAPS*8-1:0]      tap_level_i,
    output logic                    rd_en_o,
    output logic [AWIDTH-1:0]       rd_addr_o,
    input  logic [DWIDTH-1:0]       rd_data_i,
    output logic [DWIDTH-1:0]       mix_o,
    output logic                    mix_valid_o,
    output logic                    busy_o,
    output logic                    overrun_o,
    output logic [NTAPS-1:0]        unmute_trigger_o
);

    localparam int c_IW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int c_ACCW = DWIDTH + 4;
    localparam int c_PW   = DWIDTH + 9;
    localparam logic [c_IW-1:0]         c_LAST_IDX   = c_IW'(NTAPS - 1);
    localparam logic [2:0]              c_DRAIN_LAST = 3'(RD_LATENCY - 1);
    localparam logic signed [c_ACCW-1:0] c_SAT_MAX   = c_ACCW'((1 << (DWIDTH - 1)) - 1);
    localparam logic signed [c_ACCW-1:0] c_SAT_MIN   = ~c_SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [c_IW-1:0]           r_idx;
    logic [c_IW-1:0]           w_next_idx;
    logic [2:0]                r_drain_cnt;
    logic [AWIDTH-1:0]         r_wr_addr;
    logic [AWIDTH-1:0]         r_delay [NTAPS];
    logic [7:0]                r_gain  [NTAPS];
    logic [AWIDTH-1:0]         w_in_delay [NTAPS];
    logic [7:0]                w_in_level [NTAPS];
    logic [7:0]                w_entry_gain [NTAPS];
    logic                      w_start;

    logic                      r_rd_en;
    logic [AWIDTH-1:0]         r_rd_addr;
    logic [7:0]                r_iss_gain;
    logic [RD_LATENCY-1:0]     r_tag_vld;
    logic [7:0]                r_tag_gain [RD_LATENCY];

    logic signed [c_PW-1:0]    w_data_x;
    logic signed [c_PW-1:0]    w_gain_x;
    logic signed [c_PW-1:0]    w_prod;
    logic signed [c_ACCW-1:0]  w_term;
    logic signed [c_ACCW-1:0]  w_acc_next;
    logic signed [c_ACCW-1:0]  r_acc;
    logic [DWIDTH-1:0]         w_mix_sat;
    logic [DWIDTH-1:0]         r_mix;
    logic                      r_mix_valid;
    logic                      r_busy;
    logic                      r_overrun;

    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_unpack
            assign w_in_delay[k] = tap_delay_i[k*AWIDTH +: AWIDTH];
            assign w_in_level[k] = tap_level_i[k*8 +: 8];
        end
    endgenerate

    assign w_start    = (r_state == S_IDLE) && sample_tick_i;
    assign w_next_idx = r_idx + 1'b1;

`ifdef DELAY_TAP_SCHEDULER_UNMUTE_EN
    // r_delay still holds the previous pass's delays when w_start is seen,
    // so it doubles as the change-detection reference.
    logic [7:0]       r_ramp      [NTAPS];
    logic [7:0]       w_ramp_next [NTAPS];
    logic [NTAPS-1:0] w_delay_chg;
    logic [NTAPS-1:0] r_unmute;

    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_ramp
            assign w_delay_chg[k]  = (w_in_delay[k] != r_delay[k]);
            assign w_ramp_next[k]  = w_delay_chg[k]        ? 8'd0 :
                                     (r_ramp[k] == 8'hFF)  ? 8'hFF :
                                                             r_ramp[k] + 8'd1;
            assign w_entry_gain[k] = (w_ramp_next[k] < w_in_level[k]) ? w_ramp_next[k]
                                                                      : w_in_level[k];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_unmute <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                r_ramp[k] <= 8'd0;
            end
        end else begin
            r_unmute <= w_start ? w_delay_chg : '0;
            if (w_start) begin
                for (int k = 0; k < NTAPS; k++) begin
                    r_ramp[k] <= w_ramp_next[k];
                end
            end
        end
    end

    assign unmute_trigger_o = r_unmute;
`else
    generate
        for (genvar k = 0; k < NTAPS; k++) begin : g_gain
            assign w_entry_gain[k] = w_in_level[k];
        end
    endgenerate

    assign unmute_trigger_o = '0;
`endif

    // Signed sample times non-negative 9-bit gain, then /256 (arithmetic).
    assign w_data_x   = c_PW'($signed(rd_data_i));
    assign w_gain_x   = c_PW'({1'b0, r_tag_gain[RD_LATENCY-1]});
    assign w_prod     = w_data_x * w_gain_x;
    assign w_term     = c_ACCW'(w_prod >>> 8);
    // Read data is only trusted when its tag marks a real read.
    assign w_acc_next = r_acc + (r_tag_vld[RD_LATENCY-1] ? w_term : '0);

    assign w_mix_sat  = (w_acc_next > c_SAT_MAX) ? DWIDTH'(c_SAT_MAX) :
                        (w_acc_next < c_SAT_MIN) ? DWIDTH'(c_SAT_MIN) :
                                                   w_acc_next[DWIDTH-1:0];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_drain_cnt <= '0;
            r_wr_addr   <= '0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_iss_gain  <= 8'd0;
            r_tag_vld   <= '0;
            r_acc       <= '0;
            r_mix       <= '0;
            r_mix_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                r_delay[k] <= '0;
                r_gain[k]  <= 8'd0;
            end
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag_gain[i] <= 8'd0;
            end
        end else begin
            r_mix_valid <= 1'b0;

            // Tag pipeline: stage 0 mirrors the read issued last cycle.
            r_tag_vld[0]  <= r_rd_en;
            r_tag_gain[0] <= r_iss_gain;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_vld[i]  <= r_tag_vld[i-1];
                r_tag_gain[i] <= r_tag_gain[i-1];
            end

            // r_busy covers ISSUE through DONE, so a DONE-cycle tick counts too.
            if (sample_tick_i && r_busy) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (sample_tick_i) begin
                        r_state   <= S_ISSUE;
                        r_busy    <= 1'b1;
                        r_idx     <= '0;
                        r_acc     <= '0;
                        r_wr_addr <= wr_addr_i;
                        for (int k = 0; k < NTAPS; k++) begin
                            r_delay[k] <= w_in_delay[k];
                            r_gain[k]  <= w_entry_gain[k];
                        end
                        // Tap 0 is issued straight from the inputs so the
                        // first read appears in the first busy cycle.
                        r_rd_en    <= |w_in_delay[0];
                        r_rd_addr  <= wr_addr_i - w_in_delay[0];
                        r_iss_gain <= w_entry_gain[0];
                    end
                end
                S_ISSUE: begin
                    r_acc <= w_acc_next;
                    if (r_idx == c_LAST_IDX) begin
                        r_state     <= S_DRAIN;
                        r_drain_cnt <= '0;
                        r_rd_en     <= 1'b0;
                    end else begin
                        r_idx      <= w_next_idx;
                        r_rd_en    <= |r_delay[w_next_idx];
                        r_rd_addr  <= r_wr_addr - r_delay[w_next_idx];
                        r_iss_gain <= r_gain[w_next_idx];
                    end
                end
                S_DRAIN: begin
                    r_acc <= w_acc_next;
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        // The last return is folded in here, not via r_acc.
                        r_state     <= S_DONE;
                        r_mix       <= w_mix_sat;
                        r_mix_valid <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_en_o     = r_rd_en;
    assign rd_addr_o   = r_rd_addr;
    assign mix_o       = r_mix;
    assign mix_valid_o = r_mix_valid;
    assign busy_o      = r_busy;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_delay_tap_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_delay_tap_scheduler
// Purpose  : Self-checking bench for delay_tap_scheduler. A RAM model answers
//            reads with fixed latency; expected mix values come from a direct
//            arithmetic sum over the taps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_delay_tap_scheduler;

    localparam int DW       = 16;
    localparam int AW       = 15;
    localparam int NT       = 4;
    localparam int RL       = 2;
    localparam int DEPTH    = 1 << AW;
    localparam int PASS_LEN = NT + RL + 1;

    logic           clk = 1'b0;
    logic           srst;
    logic           tick;
    logic [AW-1:0]  wr_addr;
    logic [NT*AW-1:0] tap_delay;
    logic [NT*8-1:0]  tap_level;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic [DW-1:0]  mix;
    logic           mix_valid;
    logic           busy;
    logic           overrun;
    logic [NT-1:0]  unmute;

    always #5 clk = ~clk;

    delay_tap_scheduler #(
        .DWIDTH(DW), .AWIDTH(AW), .NTAPS(NT), .RD_LATENCY(RL)
    ) dut (
        .clk_i(clk), .srst_i(srst), .sample_tick_i(tick),
        .wr_addr_i(wr_addr), .tap_delay_i(tap_delay), .tap_level_i(tap_level),
        .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
        .mix_o(mix), .mix_valid_o(mix_valid), .busy_o(busy),
        .overrun_o(overrun), .unmute_trigger_o(unmute)
    );

    // Delay-line RAM with two cycles of read latency; junk when not read.
    logic signed [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_pipe;
    always @(posedge clk) begin
        ram_pipe <= rd_en ? mem[rd_addr] : DW'($urandom);
        rd_data  <= ram_pipe;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int cur_wr;
    int cur_delay [NT];
    int cur_level [NT];
    int eff       [NT];
    int m_prev    [NT];
    int m_ramp    [NT];
    logic [NT-1:0] exp_trig;
    bit m_overrun;

    function automatic void model_reset();
        for (int k = 0; k < NT; k++) begin
            m_prev[k] = 0;
            m_ramp[k] = 0;
        end
        m_overrun = 0;
    endfunction

    function automatic void model_start();
        exp_trig = '0;
        for (int k = 0; k < NT; k++) begin
`ifdef DELAY_TAP_SCHEDULER_UNMUTE_EN
            if (cur_delay[k] != m_prev[k]) begin
                m_ramp[k]   = 0;
                exp_trig[k] = 1'b1;
            end else begin
                m_ramp[k] = (m_ramp[k] >= 255) ? 255 : m_ramp[k] + 1;
            end
            m_prev[k] = cur_delay[k];
            eff[k]    = (m_ramp[k] < cur_level[k]) ? m_ramp[k] : cur_level[k];
`else
            eff[k] = cur_level[k];
`endif
        end
    endfunction

    function automatic int tap_addr(input int k);
        return ((cur_wr - cur_delay[k]) % DEPTH + DEPTH) % DEPTH;
    endfunction

    function automatic int model_mix();
        int acc = 0;
        for (int k = 0; k < NT; k++) begin
            if (cur_delay[k] != 0) begin
                acc += (int'(mem[tap_addr(k)]) * eff[k]) >>> 8;
            end
        end
        if (acc > 32767)  acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic drive_inputs();
        wr_addr = AW'(cur_wr);
        for (int k = 0; k < NT; k++) begin
            tap_delay[k*AW +: AW] = AW'(cur_delay[k]);
            tap_level[k*8 +: 8]   = 8'(cur_level[k]);
        end
    endtask

    // One pass; tick2_at > 0 fires an extra tick that many cycles after the first.
    task automatic do_pass(input string name, input int tick2_at, output int got_mix);
        int exp_addr[$];
        int got_addr[$];
        int exp_mix;
        int vcyc;
        int pulses;
        model_start();
        for (int k = 0; k < NT; k++) begin
            if (cur_delay[k] != 0) exp_addr.push_back(tap_addr(k));
        end
        exp_mix = model_mix();
        if (tick2_at > 0 && tick2_at <= PASS_LEN) m_overrun = 1;
        @(negedge clk);
        drive_inputs();
        tick   = 1'b1;
        vcyc   = -1;
        pulses = 0;
        got_mix = 0;
        for (int c = 1; c <= PASS_LEN + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                tick = 1'b0;
                check({name, " busy"}, busy, 1);
                check({name, " unmute"}, unmute, exp_trig);
            end
            if (c == 2) begin
                wr_addr   = AW'($urandom);
                tap_delay = (NT*AW)'({$urandom, $urandom});
                tap_level = (NT*8)'($urandom);
            end
            if (c == tick2_at)           tick = 1'b1;
            else if (c == tick2_at + 1)  tick = 1'b0;
            if (rd_en) got_addr.push_back(int'(rd_addr));
            if (mix_valid) begin
                pulses++;
                if (vcyc < 0) begin
                    vcyc    = c;
                    got_mix = int'($signed(mix));
                end
            end
            if (c == PASS_LEN + 1) check({name, " busy_end"}, busy, 0);
        end
        check({name, " latency"}, vcyc, PASS_LEN);
        check({name, " pulses"}, pulses, 1);
        check({name, " nreads"}, got_addr.size(), exp_addr.size());
        for (int i = 0; i < exp_addr.size(); i++) begin
            check({name, " rd_addr"}, (i < got_addr.size()) ? got_addr[i] : -1, exp_addr[i]);
        end
        check({name, " mix"}, got_mix, exp_mix);
        check({name, " mix_held"}, $signed(mix), exp_mix);
        check({name, " overrun"}, overrun, m_overrun);
    endtask

    task automatic check_all_zero(input string name);
        check({name, " rd_en"}, rd_en, 0);
        check({name, " rd_addr"}, rd_addr, 0);
        check({name, " mix"}, mix, 0);
        check({name, " mix_valid"}, mix_valid, 0);
        check({name, " busy"}, busy, 0);
        check({name, " overrun"}, overrun, 0);
        check({name, " unmute"}, unmute, 0);
    endtask

    task automatic set_taps(input int wr, input int d0, input int d1, input int d2,
                            input int d3, input int lvl);
        cur_wr = wr;
        cur_delay[0] = d0; cur_delay[1] = d1; cur_delay[2] = d2; cur_delay[3] = d3;
        for (int k = 0; k < NT; k++) cur_level[k] = lvl;
    endtask

    initial begin
        int m;
        int vseen;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        srst = 1'b1; tick = 1'b0; wr_addr = '0; tap_delay = '0; tap_level = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        srst = 1'b0;

        // Basic address sequence and latency.
        set_taps(100, 10, 20, 30, 40, 0);
        for (int k = 0; k < NT; k++) cur_level[k] = int'($urandom_range(0, 255));
        do_pass("basic", 0, m);

        // Write pointer wrap-around.
        set_taps(5, 10, 0, 0, 0, 255);
        do_pass("wrap", 0, m);

        // Positive and negative saturation.
        set_taps(1000, 10, 20, 30, 40, 255);
        for (int k = 0; k < NT; k++) mem[tap_addr(k)] = 16'sd16000;
        do_pass("sat_pos", 0, m);
`ifndef DELAY_TAP_SCHEDULER_UNMUTE_EN
        check("sat_pos literal", m, 32767);
`endif
        for (int k = 0; k < NT; k++) mem[tap_addr(k)] = -16'sd16000;
        do_pass("sat_neg", 0, m);
`ifndef DELAY_TAP_SCHEDULER_UNMUTE_EN
        check("sat_neg literal", m, -32768);
`endif

        // Single active tap at half gain.
        set_taps(100, 0, 20, 0, 0, 128);
        mem[80] = 16'sd1000;
        do_pass("single", 0, m);
`ifndef DELAY_TAP_SCHEDULER_UNMUTE_EN
        check("single literal", m, 500);
`endif

        // Randomised passes, some taps off, some extreme samples.
        for (int n = 0; n < 25; n++) begin
            cur_wr = int'($urandom_range(0, DEPTH - 1));
            for (int k = 0; k < NT; k++) begin
                cur_delay[k] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, DEPTH - 1));
                cur_level[k] = int'($urandom_range(0, 255));
                if ($urandom_range(0, 4) == 0) mem[tap_addr(k)] = ($urandom_range(0, 1) == 0) ? 16'sh7FFF : 16'sh8000;
            end
            do_pass("random", 0, m);
        end

        // Overrun: extra tick 3 cycles in is dropped and sticks.
        set_taps(200, 1, 2, 3, 4, 255);
        do_pass("ovr3", 3, m);
        do_pass("ovr_sticky", 0, m);

        // Reset two cycles into a pass aborts it.
        set_taps(300, 7, 8, 9, 10, 255);
        @(negedge clk);
        drive_inputs();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        model_reset();
        check_all_zero("abort");
        vseen = 0;
        for (int c = 0; c < PASS_LEN + 3; c++) begin
            @(negedge clk);
            if (mix_valid) vseen++;
        end
        check("abort no_valid", vseen, 0);

        // Tick during the DONE cycle is an overrun too.
        set_taps(400, 11, 0, 13, 0, 200);
        do_pass("ovr_done", PASS_LEN, m);

`ifdef DELAY_TAP_SCHEDULER_UNMUTE_EN
        // Gain ramp after a delay change: 0,1,2,... per pass up to the level.
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        model_reset();
        set_taps(100, 10, 0, 0, 0, 200);
        do_pass("um_first", 0, m);
        do_pass("um_steady", 0, m);
        set_taps(100, 12, 0, 0, 0, 200);
        mem[88] = 16'sd25600;
        for (int n = 0; n <= 205; n++) do_pass("um_ramp", 0, m);
        check("um_ramp literal", m, 20000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
